// File: rtl/gpu_line_drawer_if.sv
// Line channel between the GPU controller and the line rasteriser, plus the pixel output stream.
// Latency: none, wiring only.
// Backpressure: pixel stream uses valid/ready; the command side is a level request with a completion pulse.
interface gpu_line_drawer_if #(
    parameter int WIDTH_BITS  = 10,
    parameter int HEIGHT_BITS = 9
);
    logic                   run_line_i;
    logic [WIDTH_BITS-1:0]  x1_i;
    logic [HEIGHT_BITS-1:0] y1_i;
    logic [WIDTH_BITS-1:0]  x2_i;
    logic [HEIGHT_BITS-1:0] y2_i;
    logic                   pixel_ready_i;
    logic                   pixel_valid_o;
    logic [WIDTH_BITS-1:0]  pixel_x_o;
    logic [HEIGHT_BITS-1:0] pixel_y_o;
    logic                   busy_o;
    logic                   finished_line_o;

    // Controller / frame-buffer side
    modport master (
        output run_line_i, x1_i, y1_i, x2_i, y2_i, pixel_ready_i,
        input  pixel_valid_o, pixel_x_o, pixel_y_o, busy_o, finished_line_o
    );

    // Line drawer side
    modport slave (
        input  run_line_i, x1_i, y1_i, x2_i, y2_i, pixel_ready_i,
        output pixel_valid_o, pixel_x_o, pixel_y_o, busy_o, finished_line_o
    );
endinterface

// File: rtl/gpu_line_drawer.sv
// Bresenham line rasteriser: one pixel coordinate per accepted valid/ready beat, one-cycle finish pulse.
// Latency: run sampled at edge N -> first pixel valid after edge N+1 (one SETUP cycle); finish pulse the cycle after the last beat.
// Backpressure: pixel_ready_i low freezes the current pixel and all stepping state; nothing is dropped or repeated.
module gpu_line_drawer #(
    parameter int WIDTH_BITS  = 10,
    parameter int HEIGHT_BITS = 9,
    parameter int ERR_BITS    = ((WIDTH_BITS > HEIGHT_BITS) ? WIDTH_BITS : HEIGHT_BITS) + 2
) (
    input  logic             clk,
    input  logic             n_rst,
    gpu_line_drawer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic                       armed_q, armed_d;
    logic [WIDTH_BITS-1:0]      x1_q, x1_d, x2_q, x2_d, cur_x_q, cur_x_d;
    logic [HEIGHT_BITS-1:0]     y1_q, y1_d, y2_q, y2_d, cur_y_q, cur_y_d;
    logic signed [ERR_BITS-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                       sx_q, sx_d, sy_q, sy_d;

    logic                       start;
    logic                       fire;
    logic                       at_end;
    logic signed [ERR_BITS-1:0] x1_s, x2_s, y1_s, y2_s;
    logic signed [ERR_BITS-1:0] adx, ady;
    logic signed [ERR_BITS:0]   e2, dx_ext, dy_ext;
    logic                       step_x, step_y;
    logic signed [ERR_BITS-1:0] err_step;

    // A new line is only taken once run has been seen low since the previous one
    assign start  = (state_q == IDLE) && bus.run_line_i && armed_q;
    assign fire   = (state_q == DRAW) && bus.pixel_ready_i;
    assign at_end = (cur_x_q == x2_q) && (cur_y_q == y2_q);

    // Signed views of the latched endpoints, magnitudes for setup and the Bresenham step decision
    always_comb begin
        x1_s   = $signed({{(ERR_BITS-WIDTH_BITS){1'b0}}, x1_q});
        x2_s   = $signed({{(ERR_BITS-WIDTH_BITS){1'b0}}, x2_q});
        y1_s   = $signed({{(ERR_BITS-HEIGHT_BITS){1'b0}}, y1_q});
        y2_s   = $signed({{(ERR_BITS-HEIGHT_BITS){1'b0}}, y2_q});
        adx    = (x2_s >= x1_s) ? (x2_s - x1_s) : (x1_s - x2_s);
        ady    = (y2_s >= y1_s) ? (y2_s - y1_s) : (y1_s - y2_s);
        e2     = $signed({err_q, 1'b0});
        dx_ext = $signed({dx_q[ERR_BITS-1], dx_q});
        dy_ext = $signed({dy_q[ERR_BITS-1], dy_q});
        step_x = (e2 >= dy_ext);
        step_y = (e2 <= dx_ext);
        err_step = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
    end

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   state_d = DRAW;
            DRAW:    if (fire && at_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            armed_q <= 1'b1;
            x1_q    <= '0;
            y1_q    <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
        end else begin
            armed_q <= armed_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            x2_q    <= x2_d;
            y2_q    <= y2_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
        end
    end

    // Datapath next values: latch in IDLE, derive stepping terms in SETUP, walk the line in DRAW
    always_comb begin
        armed_d = armed_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        x2_d    = x2_q;
        y2_d    = y2_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        sx_d    = sx_q;
        sy_d    = sy_q;

        if (!bus.run_line_i) armed_d = 1'b1;
        if (start)           armed_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x1_d = bus.x1_i;
                    y1_d = bus.y1_i;
                    x2_d = bus.x2_i;
                    y2_d = bus.y2_i;
                end
            end
            SETUP: begin
                dx_d    = adx;
                dy_d    = -ady;
                sx_d    = (x2_q >= x1_q);
                sy_d    = (y2_q >= y1_q);
                err_d   = adx - ady;
                cur_x_d = x1_q;
                cur_y_d = y1_q;
            end
            DRAW: begin
                if (fire && !at_end) begin
                    err_d = err_step;
                    if (step_x) cur_x_d = sx_q ? (cur_x_q + 1'b1) : (cur_x_q - 1'b1);
                    if (step_y) cur_y_d = sy_q ? (cur_y_q + 1'b1) : (cur_y_q - 1'b1);
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state; the pixel is the current walk position
    always_comb begin
        bus.pixel_valid_o   = (state_q == DRAW);
        bus.busy_o          = (state_q != IDLE);
        bus.finished_line_o = (state_q == DONE);
        bus.pixel_x_o       = cur_x_q;
        bus.pixel_y_o       = cur_y_q;
    end
endmodule

// File: tb/tb_gpu_line_drawer.sv
// Bench for the Bresenham line drawer: directed lines plus randomized lines against a textbook model.
// Latency: checks first pixel two edges after run is driven, finish pulse one cycle after the last beat.
// Backpressure: random and directed ready stalls, with pixel stability checked during stalls.
module tb_gpu_line_drawer;
    localparam int WB = 10;
    localparam int HB = 9;

    logic clk;
    logic n_rst;
    int   checks   = 0;
    int   failures = 0;
    int   exp_x[$];
    int   exp_y[$];
    int   seen_cycles[$];

    gpu_line_drawer_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) bus();

    gpu_line_drawer #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer Bresenham walk over plain ints, producing the full pixel list
    task automatic model_line(input int x1, input int y1, input int x2, input int y2);
        int dx, dy, sx, sy, err, e2, x, y;
        exp_x.delete();
        exp_y.delete();
        dx  = (x2 >= x1) ? (x2 - x1) : (x1 - x2);
        dy  = (y2 >= y1) ? (y1 - y2) : (y2 - y1);
        sx  = (x2 >= x1) ? 1 : -1;
        sy  = (y2 >= y1) ? 1 : -1;
        err = dx + dy;
        x   = x1;
        y   = y1;
        for (int i = 0; i < 4096; i++) begin
            exp_x.push_back(x);
            exp_y.push_back(y);
            if (x == x2 && y == y2) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err = err + dy; x = x + sx; end
            if (e2 <= dx) begin err = err + dx; y = y + sy; end
        end
    endtask

    task automatic set_expected(input int n, input int xs[8], input int ys[8]);
        exp_x.delete();
        exp_y.delete();
        for (int i = 0; i < n; i++) begin
            exp_x.push_back(xs[i]);
            exp_y.push_back(ys[i]);
        end
    endtask

    // Issue one line at a negedge and follow it to completion against exp_x/exp_y.
    // ready_mode: 0 always ready, 1 random, 2 three-cycle stall on the second pixel.
    task automatic run_and_check(input string name, input int x1, input int y1, input int x2, input int y2,
                                 input int ready_mode, input bit hold_run);
        int acc, cyc, seen, bp_left, want_cnt, budget, ax, ay, px, py, adx, ady;
        bit done, stalled, rdy;
        acc = 0; cyc = 0; seen = 0; bp_left = 3; done = 0; stalled = 0; px = 0; py = 0;
        adx = (x2 >= x1) ? (x2 - x1) : (x1 - x2);
        ady = (y2 >= y1) ? (y2 - y1) : (y1 - y2);
        want_cnt = ((adx > ady) ? adx : ady) + 1;
        budget   = 4 * want_cnt + 40;
        seen_cycles.delete();
        bus.x1_i = WB'(x1);
        bus.y1_i = HB'(y1);
        bus.x2_i = WB'(x2);
        bus.y2_i = HB'(y2);
        bus.run_line_i    = 1'b1;
        bus.pixel_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.pixel_valid_o !== 1'b0 || bus.busy_o !== 1'b1)
            begin failures++; $display("FAIL %s setup_cycle valid=%b busy=%b want valid=0 busy=1", name, bus.pixel_valid_o, bus.busy_o); end
        @(negedge clk);
        checks++;
        if (bus.pixel_valid_o !== 1'b1)
            begin failures++; $display("FAIL %s first_pixel_latency valid=%b want 1", name, bus.pixel_valid_o); end
        while (!done && cyc < budget) begin
            if (!hold_run && acc > 0) begin
                bus.run_line_i = 1'b0;
                bus.x1_i = WB'($urandom);
                bus.y1_i = HB'($urandom);
                bus.x2_i = WB'($urandom);
                bus.y2_i = HB'($urandom);
            end
            if (bus.pixel_valid_o === 1'b1) begin
                ax = int'(bus.pixel_x_o);
                ay = int'(bus.pixel_y_o);
                if (stalled) begin
                    checks++;
                    if (ax !== px || ay !== py)
                        begin failures++; $display("FAIL %s stall_stable got=(%0d,%0d) want=(%0d,%0d)", name, ax, ay, px, py); end
                end
                checks++;
                if (ax !== exp_x[acc] || ay !== exp_y[acc])
                    begin failures++; $display("FAIL %s pixel idx=%0d got=(%0d,%0d) want=(%0d,%0d)", name, acc, ax, ay, exp_x[acc], exp_y[acc]); end
                seen++;
                case (ready_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 2) != 0);
                    default: begin
                        if (acc == 1 && bp_left > 0) begin rdy = 1'b0; bp_left--; end
                        else rdy = 1'b1;
                    end
                endcase
                bus.pixel_ready_i = rdy;
                if (rdy) begin
                    seen_cycles.push_back(seen);
                    seen = 0;
                    acc++;
                    stalled = 1'b0;
                    if (acc == exp_x.size()) done = 1'b1;
                end else begin
                    stalled = 1'b1;
                    px = ax;
                    py = ay;
                end
            end else begin
                checks++;
                failures++;
                $display("FAIL %s valid_dropped cycle=%0d got=%b want=1", name, cyc, bus.pixel_valid_o);
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!done) begin failures++; $display("FAIL %s timeout accepted=%0d want=%0d", name, acc, exp_x.size()); end
        checks++;
        if (acc !== want_cnt) begin failures++; $display("FAIL %s pixel_count got=%0d want=%0d", name, acc, want_cnt); end
        checks++;
        if (bus.finished_line_o !== 1'b1 || bus.pixel_valid_o !== 1'b0)
            begin failures++; $display("FAIL %s finish_pulse finished=%b valid=%b want 1/0", name, bus.finished_line_o, bus.pixel_valid_o); end
        if (!hold_run) bus.run_line_i = 1'b0;
        bus.pixel_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.finished_line_o !== 1'b0 || bus.busy_o !== 1'b0)
            begin failures++; $display("FAIL %s finish_width finished=%b busy=%b want 0/0", name, bus.finished_line_o, bus.busy_o); end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        bus.run_line_i = 1'b0;
        bus.pixel_ready_i = 1'b1;
        bus.x1_i = '0; bus.y1_i = '0; bus.x2_i = '0; bus.y2_i = '0;
        #1;
        checks++;
        if (bus.pixel_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.pixel_valid_o); end
        checks++;
        if (bus.pixel_x_o !== '0 || bus.pixel_y_o !== '0)
            begin failures++; $display("FAIL reset_pixel got=(%0d,%0d) want=(0,0)", bus.pixel_x_o, bus.pixel_y_o); end
        checks++;
        if (bus.busy_o !== 1'b0 || bus.finished_line_o !== 1'b0)
            begin failures++; $display("FAIL reset_status busy=%b finished=%b want 0/0", bus.busy_o, bus.finished_line_o); end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.pixel_valid_o !== 1'b0)
            begin failures++; $display("FAIL reset_release busy=%b valid=%b want 0/0", bus.busy_o, bus.pixel_valid_o); end
    endtask

    task automatic test_horizontal();
        set_expected(4, '{0, 1, 2, 3, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
        run_and_check("horizontal", 0, 0, 3, 0, 0, 1'b0);
    endtask

    task automatic test_steep_negative();
        set_expected(6, '{2, 2, 1, 1, 0, 0, 0, 0}, '{5, 4, 3, 2, 1, 0, 0, 0});
        run_and_check("steep_neg", 2, 5, 0, 0, 0, 1'b0);
    endtask

    task automatic test_point();
        set_expected(1, '{5, 0, 0, 0, 0, 0, 0, 0}, '{5, 0, 0, 0, 0, 0, 0, 0});
        run_and_check("point", 5, 5, 5, 5, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        set_expected(3, '{0, 1, 2, 0, 0, 0, 0, 0}, '{0, 1, 2, 0, 0, 0, 0, 0});
        run_and_check("backpressure", 0, 0, 2, 2, 2, 1'b0);
        checks++;
        if (seen_cycles.size() !== 3 || seen_cycles[1] !== 4)
            begin failures++; $display("FAIL backpressure_hold beats=%0d hold=%0d want beats=3 hold=4", seen_cycles.size(), (seen_cycles.size() > 1) ? seen_cycles[1] : -1); end
    endtask

    task automatic test_rearm();
        set_expected(2, '{0, 1, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
        run_and_check("rearm_first", 0, 0, 1, 0, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.busy_o !== 1'b0 || bus.pixel_valid_o !== 1'b0)
                begin failures++; $display("FAIL rearm_hold cycle=%0d busy=%b valid=%b want 0/0", i, bus.busy_o, bus.pixel_valid_o); end
        end
        bus.run_line_i = 1'b0;
        @(negedge clk);
        set_expected(3, '{1, 1, 1, 0, 0, 0, 0, 0}, '{1, 2, 3, 0, 0, 0, 0, 0});
        run_and_check("rearm_second", 1, 1, 1, 3, 0, 1'b0);
    endtask

    task automatic test_reset_midline();
        bit reached;
        reached = 1'b0;
        bus.x1_i = WB'(0); bus.y1_i = HB'(0); bus.x2_i = WB'(9); bus.y2_i = HB'(0);
        bus.run_line_i = 1'b1;
        bus.pixel_ready_i = 1'b1;
        for (int i = 0; i < 10 && !reached; i++) begin
            @(negedge clk);
            if (bus.pixel_valid_o === 1'b1 && bus.pixel_x_o === WB'(1)) reached = 1'b1;
        end
        checks++;
        if (!reached) begin failures++; $display("FAIL midline_reach got=%b want=1", reached); end
        #2 n_rst = 1'b0;
        bus.run_line_i = 1'b0;
        #1;
        checks++;
        if (bus.pixel_valid_o !== 1'b0 || bus.pixel_x_o !== '0 || bus.pixel_y_o !== '0 || bus.busy_o !== 1'b0 || bus.finished_line_o !== 1'b0)
            begin failures++; $display("FAIL midline_async valid=%b x=%0d y=%0d busy=%b fin=%b want all 0", bus.pixel_valid_o, bus.pixel_x_o, bus.pixel_y_o, bus.busy_o, bus.finished_line_o); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) n_rst = 1'b1;
            checks++;
            if (bus.finished_line_o !== 1'b0 || bus.busy_o !== 1'b0)
                begin failures++; $display("FAIL midline_no_finish cycle=%0d fin=%b busy=%b want 0/0", i, bus.finished_line_o, bus.busy_o); end
        end
        model_line(4, 2, 7, 3);
        run_and_check("after_reset", 4, 2, 7, 3, 0, 1'b0);
    endtask

    task automatic test_random();
        int x1, y1, x2, y2;
        for (int n = 0; n < 24; n++) begin
            if (n < 8) begin
                x1 = $urandom_range(0, 1023); y1 = $urandom_range(0, 511);
                x2 = $urandom_range(0, 1023); y2 = $urandom_range(0, 511);
            end else begin
                x1 = $urandom_range(0, 15); y1 = $urandom_range(0, 15);
                x2 = $urandom_range(0, 15); y2 = $urandom_range(0, 15);
            end
            model_line(x1, y1, x2, y2);
            run_and_check("random", x1, y1, x2, y2, (n % 3 == 0) ? 0 : 1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_steep_negative();
        test_point();
        test_backpressure();
        test_rearm();
        test_reset_midline();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
